// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the ysyx_24080006 core: stage records, IFU FSM encoding, AXI constants.
// IFU_PERF_EN / SOC_MODE / NPC_MODE select the optional fetch-address map helpers used by the IFU.
package ysyx_24080006_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic        jump;
        logic        branch;
        logic        flush;
    } stage_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_t;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        RESP     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_EXU = 2'd3
    } ifu_fsm_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [31:0] FLASH_BASE = 32'h3000_0000;
    localparam logic [31:0] FLASH_LAST = 32'h3FFF_FFFF;
    localparam logic [31:0] SRAM_BASE  = 32'h0F00_0000;
    localparam logic [31:0] SRAM_LAST  = 32'h0FFF_FFFF;
    localparam logic [31:0] SDRAM_BASE = 32'hA000_0000;
    localparam logic [31:0] SDRAM_LAST = 32'hBFFF_FFFF;
    localparam logic [31:0] NPC_BASE   = 32'h8000_0000;
    localparam logic [31:0] NPC_LAST   = 32'h87FF_FFFF;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi_if.sv
// AXI4 bundle between a core-side master and the interconnect; all five channels are present
// even when a master only uses the read side.
interface ysyx_24080006_axi;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/ysyx_24080006_if_stage.sv
// Serialised instruction fetch: REQ -> RESP -> ISSUE -> WAIT_EXU, one AXI read beat per loop.
// Defining IFU_PERF_EN adds fetch-latency counters and (SOC_MODE) a PC range check.
module ysyx_24080006_if_stage
    import ysyx_24080006_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter logic [3:0]  AXI_ID   = 4'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  stage_t           exu2ifu,
    output logic             ifu2exu_ready,
    output fetch_t           ifu2idu,
    input  logic             idu2ifu_ready,
    ysyx_24080006_axi.master axi_ifu
);

    ifu_fsm_e    state;
    ifu_fsm_e    state_next;
    logic [31:0] pc;

    logic ar_fire;
    logic r_fire;
    logic idu_fire;
    logic exu_fire;

    assign ar_fire  = axi_ifu.arvalid & axi_ifu.arready;
    assign r_fire   = (state == RESP) & axi_ifu.rvalid;
    assign idu_fire = (state == ISSUE) & ifu2idu.valid & idu2ifu_ready;
    assign exu_fire = (state == WAIT_EXU) & exu2ifu.valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            REQ:      if (ar_fire)  state_next = RESP;
            RESP:     if (r_fire)   state_next = ISSUE;
            ISSUE:    if (idu_fire) state_next = WAIT_EXU;
            WAIT_EXU: if (exu_fire) state_next = REQ;
            default:                state_next = REQ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ifu2idu <= '0;
        end else begin
            if (r_fire) begin
                ifu2idu.valid <= 1'b1;
                ifu2idu.pc    <= pc;
                ifu2idu.inst  <= axi_ifu.rdata;
                ifu2idu.fault <= (axi_ifu.rresp != AXI_RESP_OKAY);
            end else if (idu_fire) begin
                ifu2idu.valid <= 1'b0;
            end
            if (exu_fire) begin
                pc <= (exu2ifu.jump | exu2ifu.branch) ? exu2ifu.dnpc : pc + 32'd4;
            end
        end
    end

    assign ifu2exu_ready = (state == WAIT_EXU);

    // arvalid is gated by reset so the bus sees an idle master while reset is held.
    always_comb begin
        axi_ifu.arvalid = reset & (state == REQ);
        axi_ifu.araddr  = pc;
        axi_ifu.arid    = AXI_ID;
        axi_ifu.arlen   = 8'd0;
        axi_ifu.arsize  = AXI_SIZE_4B;
        axi_ifu.arburst = AXI_BURST_INCR;
        axi_ifu.rready  = (state == RESP);
        axi_ifu.awvalid = 1'b0;
        axi_ifu.awaddr  = 32'd0;
        axi_ifu.awid    = AXI_ID;
        axi_ifu.awlen   = 8'd0;
        axi_ifu.awsize  = AXI_SIZE_4B;
        axi_ifu.awburst = AXI_BURST_INCR;
        axi_ifu.wvalid  = 1'b0;
        axi_ifu.wdata   = 32'd0;
        axi_ifu.wstrb   = 4'd0;
        axi_ifu.wlast   = 1'b0;
        axi_ifu.bready  = 1'b1;
    end

    logic unused_inputs;
    assign unused_inputs = ^{axi_ifu.rlast, axi_ifu.rid, axi_ifu.awready, axi_ifu.wready,
                             axi_ifu.bvalid, axi_ifu.bresp, axi_ifu.bid, exu2ifu.flush,
                             exu2ifu.pc};

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cycles;
    logic [31:0] fetch_last_cycles;
    logic [31:0] fetch_total;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cycles      <= '0;
            fetch_last_cycles <= '0;
            fetch_total       <= '0;
        end else begin
            if (exu_fire) begin
                fetch_cycles <= '0;
            end else if (state == REQ || state == RESP) begin
                fetch_cycles <= fetch_cycles + 32'd1;
            end
            if (r_fire) begin
                fetch_last_cycles <= fetch_cycles;
                fetch_total       <= fetch_total + 32'd1;
            end
        end
    end

`ifdef SOC_MODE
    logic pc_legal;
    always_comb begin
        pc_legal = in_range(pc, FLASH_BASE, FLASH_LAST) | in_range(pc, SRAM_BASE, SRAM_LAST) |
                   in_range(pc, SDRAM_BASE, SDRAM_LAST);
`ifdef NPC_MODE
        pc_legal = pc_legal | in_range(pc, NPC_BASE, NPC_LAST);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset && state == REQ && !pc_legal) begin
            $display("IFU: fetch address %h outside memory map", pc);
            $finish;
        end
    end
`endif
`endif

endmodule
